// File: rtl/haar_load_pkg.sv
// ---------------------------------------------------------------------------
// haar_load_pkg
//   Shared definitions for the Haar cascade ROM load sequencer.
//   - load_state_e : sequencer FSM states (IDLE/ISSUE/DRAIN/DONE)
//   - stage layout constants (classifiers, params per classifier, thresholds)
//   - MAX_ROM_LATENCY : deepest ROM read pipeline the sequencer tracks
//   - width_of()   : $clog2 that never returns 0, so 1-entry ranges still
//                    get a 1-bit signal
// ---------------------------------------------------------------------------
package haar_load_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } load_state_e;

    localparam int unsigned CLASSIFIERS_PER_STAGE = 10;
    localparam int unsigned PARAMS_PER_CLASSIFIER = 19;
    localparam int unsigned THRESHOLDS_PER_STAGE  = 3;
    localparam int unsigned STAGE_WORDS_DEFAULT   =
        CLASSIFIERS_PER_STAGE * PARAMS_PER_CLASSIFIER + THRESHOLDS_PER_STAGE;
    localparam int unsigned MAX_ROM_LATENCY       = 4;

    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/haar_load_addr_gen.sv
// ---------------------------------------------------------------------------
// haar_load_addr_gen
//   Stage/index counters for the ROM load and the stage*STRIDE+index address.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : return both counters to 0 (new load)
//     advance     : one address consumed this cycle; step the counters
//     stage/index : current counter values (address being offered)
//     addr        : ROM address for the current counters (combinational)
//     last        : current address is the final one of the final stage
//   The index counts 0..STRIDE-1 so a per-stage checksum slot is included
//   when STRIDE = STAGE_WORDS + 1. Counters stop on the last address rather
//   than wrapping past the final stage.
// ---------------------------------------------------------------------------
module haar_load_addr_gen
    import haar_load_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned STRIDE     = STAGE_WORDS_DEFAULT,
    parameter int unsigned SW         = width_of(NUM_STAGES),
    parameter int unsigned IW         = width_of(STRIDE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    output logic [SW-1:0]         stage,
    output logic [IW-1:0]         index,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [SW-1:0] stage_q, stage_d;
    logic [IW-1:0] index_q, index_d;
    logic          index_wrap;

    assign index_wrap = (index_q == IW'(STRIDE - 1));
    assign last       = index_wrap && (stage_q == SW'(NUM_STAGES - 1));

    always_comb begin
        stage_d = stage_q;
        index_d = index_q;
        if (clear) begin
            stage_d = '0;
            index_d = '0;
        end else if (advance && !last) begin
            if (index_wrap) begin
                index_d = '0;
                stage_d = stage_q + SW'(1);
            end else begin
                index_d = index_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            index_q <= '0;
        end else begin
            stage_q <= stage_d;
            index_q <= index_d;
        end
    end

    assign stage = stage_q;
    assign index = index_q;
    assign addr  = ADDR_WIDTH'(stage_q) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(index_q);

endmodule

// File: rtl/haar_rom_load_sequencer.sv
// ---------------------------------------------------------------------------
// haar_rom_load_sequencer
//   Time-multiplexes one single-port classifier ROM to load every Haar
//   cascade stage's parameters into the per-stage register files, then
//   raises ready.
//   Ports:
//     clk_fpga, reset_fpga : clock, asynchronous active-low reset
//     start                : pulse, (re)load all stages; ignored while busy
//     busy / ready / error : load in progress / all loaded cleanly / bad sum
//     rom_address, rom_q   : registered ROM address, ROM read data
//     wr_en, wr_stage, wr_index, wr_data : register-file write port
//     stage_done           : 1-cycle pulse as each stage finishes
//     dbg_state            : current FSM state (load_state_e encoding)
//   Build option: HAAR_LOAD_CHECKSUM_EN adds one mod-256 checksum word after
//   each stage's region; it is read, compared, never written. Without it the
//   regions are packed and error is held at 0.
//
//   Handshake: there is no backpressure. start is a single-cycle request
//   accepted only in IDLE/DONE; each wr_en cycle carries one valid word that
//   the register file must take in that cycle.
// ---------------------------------------------------------------------------
module haar_rom_load_sequencer
    import haar_load_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned STAGE_WORDS = STAGE_WORDS_DEFAULT,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                               clk_fpga,
    input  logic                               reset_fpga,
    input  logic                               start,
    output logic                               busy,
    output logic                               ready,
    output logic                               error,
    output logic [ADDR_WIDTH-1:0]              rom_address,
    input  logic [DATA_WIDTH-1:0]              rom_q,
    output logic                               wr_en,
    output logic [width_of(NUM_STAGES)-1:0]    wr_stage,
    output logic [width_of(STAGE_WORDS)-1:0]   wr_index,
    output logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               stage_done,
    output logic [1:0]                         dbg_state
);

`ifdef HAAR_LOAD_CHECKSUM_EN
    localparam int unsigned STRIDE = STAGE_WORDS + 1;
`else
    localparam int unsigned STRIDE = STAGE_WORDS;
`endif
    localparam int unsigned SW = width_of(NUM_STAGES);
    localparam int unsigned IW = width_of(STRIDE);
    localparam int unsigned OW = width_of(STAGE_WORDS);

    if (ROM_LATENCY < 1 || ROM_LATENCY > MAX_ROM_LATENCY) begin : g_bad_latency
        $error("ROM_LATENCY must be 1..%0d", MAX_ROM_LATENCY);
    end

    // Tag travelling alongside each ROM read.
    typedef struct packed {
        logic          valid;
        logic [SW-1:0] stage;
        logic [IW-1:0] index;
    } tag_t;

    load_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
    tag_t                  iss_q, iss_d;
    tag_t                  pipe_q [ROM_LATENCY];
    tag_t                  pipe_d [ROM_LATENCY];
    tag_t                  tail;

    logic                  start_accept;
    logic                  issue;
    logic                  upstream_valid;
    logic [SW-1:0]         gen_stage;
    logic [IW-1:0]         gen_index;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign issue        = (state_q == ISSUE);

    haar_load_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_STAGES (NUM_STAGES),
        .STRIDE     (STRIDE),
        .SW         (SW),
        .IW         (IW)
    ) u_addr_gen (
        .clk     (clk_fpga),
        .rst_n   (reset_fpga),
        .clear   (start_accept),
        .advance (issue),
        .stage   (gen_stage),
        .index   (gen_index),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    // Anything still in flight ahead of the tail. When this is clear the
    // tail holds the final read, so the next edge lands in DONE.
    always_comb begin
        upstream_valid = iss_q.valid;
        for (int i = 0; i < int'(ROM_LATENCY) - 1; i++) begin
            upstream_valid = upstream_valid | pipe_q[i].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = ISSUE;
            ISSUE:      if (gen_last) state_d = DRAIN;
            DRAIN:      if (!upstream_valid) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // The issue register is aligned with rom_address; the following
    // ROM_LATENCY-deep shift aligns the tag with rom_q.
    always_comb begin
        rom_address_d = rom_address_q;
        iss_d         = '0;
        if (issue) begin
            rom_address_d = gen_addr;
            iss_d.valid   = 1'b1;
            iss_d.stage   = gen_stage;
            iss_d.index   = gen_index;
        end
        pipe_d[0] = iss_q;
        for (int i = 1; i < int'(ROM_LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state_q       <= IDLE;
            rom_address_q <= '0;
            iss_q         <= '0;
            for (int i = 0; i < int'(ROM_LATENCY); i++) pipe_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            rom_address_q <= rom_address_d;
            iss_q         <= iss_d;
            for (int i = 0; i < int'(ROM_LATENCY); i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign tail = pipe_q[ROM_LATENCY-1];

`ifdef HAAR_LOAD_CHECKSUM_EN
    logic       csum_word;
    logic [7:0] sum_q, sum_d;
    logic       error_q, error_d;

    if (DATA_WIDTH < 8) begin : g_bad_width
        $error("checksum needs DATA_WIDTH >= 8");
    end

    // Index STAGE_WORDS is the checksum slot at the end of each region.
    assign csum_word  = tail.valid && (tail.index == IW'(STAGE_WORDS));
    assign wr_en      = tail.valid && !csum_word;
    assign stage_done = csum_word;

    always_comb begin
        sum_d   = sum_q;
        error_d = error_q;
        if (start_accept) begin
            sum_d   = '0;
            error_d = 1'b0;
        end else if (wr_en) begin
            sum_d = sum_q + rom_q[7:0];
        end else if (csum_word) begin
            sum_d = '0;
            if (rom_q[7:0] != sum_q) error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign wr_en      = tail.valid;
    assign stage_done = tail.valid && (tail.index == IW'(STAGE_WORDS - 1));
    assign error      = 1'b0;
`endif

    assign wr_stage    = tail.stage;
    assign wr_index    = OW'(tail.index);
    assign wr_data     = wr_en ? rom_q : '0;
    assign rom_address = rom_address_q;
    assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign ready       = (state_q == DONE) && !error;
    assign dbg_state   = state_q;

endmodule
